pcm_tdm_scheduler: RTL and testbench
====================================

// Module: pcm_tdm_scheduler
// PURPOSE
//  Time-division scheduler for the shared 8-bit linear->PCM compressor (pure combinational).
//  Buffers one linear sample per channel. Each time a channel's slot comes up, it routes
//  that sample through the compressor and captures the PCM byte. Assembles a fixed TDM
//  frame (slot 0 = sync word, slots 1..N_CH = channels, remaining slots = idle word).
//  Frame is shifted out serially, MSB first, one bit per clock.
// PARAMETERS
//  N_CH         4            number of input channels; legal range 1..FRAME_SLOTS-1
//  FRAME_SLOTS  8            slots per frame (8 bits each); frame = 8*FRAME_SLOTS clocks
//  SYNC_WORD    8'h9B        word sent in slot 0
//  IDLE_WORD    8'hD5        word sent in unused slots and on channel underrun
// PORTS
//  clk         in   1                     single clock, all state on rising edge
//  rst_n       in   1                     asynchronous, active-low reset
//  en          in   1                     framing enable
//  ch_valid    in   N_CH                  per-channel sample valid
//  ch_data     in   8*N_CH                linear samples, ch i at [8i+7:8i], bit7 = sign
//  ch_ready    out  N_CH                  per-channel buffer empty / can accept
//  enc_in      out  8                     linear word driven to shared compressor
//  enc_out     in   8                     PCM word returned by compressor, same cycle
//  ser_out     out  1                     serial TDM bit stream
//  frame_sync  out  1                     1-cycle pulse on bit 0 of slot 0
//  slot_idx    out  $clog2(FRAME_SLOTS)   slot currently on ser_out
//  underrun    out  N_CH                  1-cycle pulse: channel slot loaded with empty buffer
// BEHAVIOUR
//  Reset values:
//   - ser_out=0, frame_sync=0, slot_idx=0, underrun=0, enc_in=0.
//   - All buffers empty, so ch_ready = all ones. FSM = IDLE.
//  Channel buffers:
//   - One entry per channel. ch_ready[i] = ~full[i].
//   - Accept on ch_valid[i] & ch_ready[i].
//   - Cleared at the load edge of slot i+1; ch_ready[i] rises the next cycle.
//   - No accept and consume on the same edge, because ready is low while full.
//   - Buffers accept in IDLE too.
//  FSM states:
//   - IDLE: ser_out=0, counters held at 0. If en=1: shreg<=SYNC_WORD, slot=0, bit=0 -> RUN.
//   - RUN: ser_out=shreg[7], shreg shifts left each clock, bit_cnt 0..7.
//     - frame_sync=1 when slot==0 && bit==0.
//     - At bit_cnt==7: load the next slot word, bit_cnt<=0, slot<=slot+1.
//     - slot wraps from FRAME_SLOTS-1 to 0.
//  Next-slot word:
//   - slot 0: SYNC_WORD.
//   - Channel slot, full buffer: enc_in=buf, load enc_out.
//   - Channel slot, empty buffer: load IDLE_WORD and pulse underrun.
//   - All other slots: IDLE_WORD.
//   - enc_in is 0 except on channel load cycles.
//  en deassert:
//   - en is sampled only at the last bit of the last slot.
//   - If en=0 there, go to IDLE. A mid-frame drop finishes the current frame.
//   - Re-assert in IDLE restarts at slot 0.
//  Latency:
//   - A sample accepted at cycle t goes out on the next load of its slot (at most one frame).
//   - Its bit7 appears on ser_out the cycle after that load.
//  Reset mid-operation:
//   - Immediate clear to reset values; buffered samples are discarded; no partial frame completion.
//  Arithmetic: counters unsigned; slot_idx width $clog2(FRAME_SLOTS).
// STRUCTURE
//  Package pcm_pkg:
//   - SYNC_WORD/IDLE_WORD defaults.
//   - State enum {IDLE, RUN}.
//   - BITS_PER_SLOT=8.
//  Sub-module pcm_chan_buf: one-entry valid/ready holding register with consume input.
//   - Instantiated N_CH times via generate.
//  The compressor stays outside this block; the top level wires enc_in/enc_out to it.
// TESTING (bench instantiates real compressor on enc_in/enc_out)
//  1. rst_n=0 -> ser_out=0, frame_sync=0, slot_idx=0, underrun=0, ch_ready=4'hF.
//  2. en=1, no samples -> per 64 clks: 9B then 7x D5.
//     underrun[0..3] pulse at slots 1..4 loads; frame_sync every 64 clks.
//  3. ch0 sample 8'h05 -> enc_in=8'h05 at slot-1 load; slot 1 serializes 8'h34 (00110100).
//  4. ch1 sample accepted, second held valid -> ch_ready[1]=0 until slot-2 load edge.
//     ch_ready[1]=1 next clk; second sample in next frame.
//  5. en=0 at slot 3 -> frame runs through slot 7 bit 7, then IDLE with ser_out=0.
//     en=1 -> frame_sync on next cycle after restart.
//  6. rst_n low mid-slot 2 with all buffers full -> immediate reset values, ch_ready=4'hF.
//     On restart, no stale data is emitted; underruns are reported.

Source files
------------

// File: rtl/pcm_pkg.sv
// Shared types and defaults for the PCM TDM scheduler.
package pcm_pkg;

    localparam int         BITS_PER_SLOT = 8;
    localparam logic [7:0] SYNC_WORD_DEF = 8'h9B;
    localparam logic [7:0] IDLE_WORD_DEF = 8'hD5;

    typedef enum logic {IDLE, RUN} state_t;

endpackage

// File: rtl/pcm_chan_buf.sv
// One-entry holding register for a single channel's linear sample.
module pcm_chan_buf
    import pcm_pkg::*;
#(
    parameter int DATA_W = BITS_PER_SLOT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic              consume,
    output logic              full,
    output logic [DATA_W-1:0] data
);

    assign in_ready = ~full;

    // Consume and accept never coincide: ready is low whenever consume can fire.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full <= 1'b0;
        end else if (consume) begin
            full <= 1'b0;
        end else if (in_valid && !full) begin
            full <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (in_valid && !full) begin
            data <= in_data;
        end
    end

endmodule

// File: rtl/pcm_tdm_scheduler.sv
// Time-division scheduler: buffers one sample per channel, routes it through the
// shared compressor on its slot, and shifts the assembled TDM frame out MSB first.
module pcm_tdm_scheduler
    import pcm_pkg::*;
#(
    parameter int         N_CH        = 4,
    parameter int         FRAME_SLOTS = 8,
    parameter logic [7:0] SYNC_WORD   = SYNC_WORD_DEF,
    parameter logic [7:0] IDLE_WORD   = IDLE_WORD_DEF
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           en,
    input  logic [N_CH-1:0]                ch_valid,
    input  logic [8*N_CH-1:0]              ch_data,
    output logic [N_CH-1:0]                ch_ready,
    output logic [7:0]                     enc_in,
    input  logic [7:0]                     enc_out,
    output logic                           ser_out,
    output logic                           frame_sync,
    output logic [$clog2(FRAME_SLOTS)-1:0] slot_idx,
    output logic [N_CH-1:0]                underrun
);

    localparam int              SW        = $clog2(FRAME_SLOTS);
    localparam int              BW        = $clog2(BITS_PER_SLOT);
    localparam logic [SW-1:0]   LAST_SLOT = SW'(FRAME_SLOTS - 1);
    localparam logic [BW-1:0]   LAST_BIT  = BW'(BITS_PER_SLOT - 1);

    state_t          state;
    logic [7:0]      shreg;
    logic [BW-1:0]   bit_cnt;
    logic [SW-1:0]   slot;
    logic [SW-1:0]   next_slot;
    logic            load;
    logic [7:0]      next_word;
    logic [N_CH-1:0] consume;
    logic [N_CH-1:0] full;
    logic [N_CH-1:0] und_next;
    logic [7:0]      buf_data [N_CH];

    genvar g;
    generate
        for (g = 0; g < N_CH; g++) begin : g_chan
            pcm_chan_buf #(.DATA_W(8)) u_buf (
                .clk      (clk),
                .rst_n    (rst_n),
                .in_valid (ch_valid[g]),
                .in_data  (ch_data[8*g +: 8]),
                .in_ready (ch_ready[g]),
                .consume  (consume[g]),
                .full     (full[g]),
                .data     (buf_data[g])
            );
        end
    endgenerate

    assign next_slot = (slot == LAST_SLOT) ? '0 : slot + 1'b1;
    // en only matters on the final bit of the frame; elsewhere the frame always continues.
    assign load      = (state == RUN) && (bit_cnt == LAST_BIT) && !((slot == LAST_SLOT) && !en);

    always_comb begin
        next_word = (next_slot == '0) ? SYNC_WORD : IDLE_WORD;
        enc_in    = '0;
        consume   = '0;
        und_next  = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (load && (next_slot == SW'(i + 1))) begin
                if (full[i]) begin
                    enc_in     = buf_data[i];
                    next_word  = enc_out;
                    consume[i] = 1'b1;
                end else begin
                    und_next[i] = 1'b1;
                end
            end
        end
    end

    assign ser_out  = shreg[7];
    assign slot_idx = slot;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            shreg      <= '0;
            bit_cnt    <= '0;
            slot       <= '0;
            frame_sync <= 1'b0;
            underrun   <= '0;
        end else begin
            frame_sync <= 1'b0;
            underrun   <= '0;
            case (state)
                IDLE: begin
                    if (en) begin
                        state      <= RUN;
                        shreg      <= SYNC_WORD;
                        frame_sync <= 1'b1;
                    end
                end
                RUN: begin
                    if (bit_cnt != LAST_BIT) begin
                        shreg   <= {shreg[6:0], 1'b0};
                        bit_cnt <= bit_cnt + 1'b1;
                    end else if (load) begin
                        shreg      <= next_word;
                        bit_cnt    <= '0;
                        slot       <= next_slot;
                        frame_sync <= (next_slot == '0);
                        underrun   <= und_next;
                    end else begin
                        state   <= IDLE;
                        shreg   <= '0;
                        bit_cnt <= '0;
                        slot    <= '0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pcm_tdm_scheduler.sv
// Self-checking bench for pcm_tdm_scheduler with a behavioural compressor on enc_in/enc_out.
module tb_pcm_tdm_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [3:0]  ch_valid;
    logic [31:0] ch_data;
    logic [3:0]  ch_ready;
    logic [7:0]  enc_in;
    logic [7:0]  enc_out;
    logic        ser_out;
    logic        frame_sync;
    logic [2:0]  slot_idx;
    logic [3:0]  underrun;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       ser;
        logic [2:0] slot;
        logic       fs;
        logic [3:0] und;
        logic [7:0] enc;
        logic [3:0] rdy;
    } exp_t;

    typedef struct {
        logic [7:0] sample;
        logic [7:0] pcm;
    } vec_t;

    exp_t exp_q [$];
    vec_t tbl [8];

    always #5 clk = ~clk;

    // Segment/mantissa companding of sign-magnitude input, then line inversion mask.
    function automatic logic [7:0] compress(input logic [7:0] s);
        logic [6:0] m;
        logic [7:0] code;
        m = s[6:0];
        if (m[6])      code = {s[7], 3'd3, m[5:2]};
        else if (m[5]) code = {s[7], 3'd2, m[4:1]};
        else if (m[4]) code = {s[7], 3'd1, m[3:0]};
        else           code = {s[7], 3'd0, m[3:0]};
        return code ^ 8'h31;
    endfunction

    assign enc_out = compress(enc_in);

    pcm_tdm_scheduler dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .ch_valid   (ch_valid),
        .ch_data    (ch_data),
        .ch_ready   (ch_ready),
        .enc_in     (enc_in),
        .enc_out    (enc_out),
        .ser_out    (ser_out),
        .frame_sync (frame_sync),
        .slot_idx   (slot_idx),
        .underrun   (underrun)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_frame(input logic [31:0] pcm, input logic [31:0] samp,
                                input logic [3:0] full, input logic [3:0] refill);
        exp_t       e;
        logic [7:0] w;
        int         s;
        int         b;
        for (int k = 0; k < 64; k++) begin
            s = k / 8;
            b = k % 8;
            if (s == 0)                    w = 8'h9B;
            else if (s <= 4 && full[s-1])  w = pcm[8*(s-1) +: 8];
            else                           w = 8'hD5;
            e.ser  = w[7-b];
            e.slot = 3'(s);
            e.fs   = (k == 0);
            e.und  = '0;
            if (b == 0 && s >= 1 && s <= 4 && !full[s-1]) e.und[s-1] = 1'b1;
            e.enc = '0;
            if (b == 7 && s <= 3 && full[s]) e.enc = samp[8*s +: 8];
            for (int i = 0; i < 4; i++) begin
                if (!full[i])       e.rdy[i] = 1'b1;
                else if (refill[i]) e.rdy[i] = (k == 8*(i+1));
                else                e.rdy[i] = (k >= 8*(i+1));
            end
            exp_q.push_back(e);
        end
    endtask

    task automatic expect_idle(input int n);
        exp_t e;
        e.ser  = 1'b0;
        e.slot = '0;
        e.fs   = 1'b0;
        e.und  = '0;
        e.enc  = '0;
        e.rdy  = 4'hF;
        for (int k = 0; k < n; k++) exp_q.push_back(e);
    endtask

    task automatic drain(input int n, input logic [3:0] vld_after, input logic [31:0] data_after);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0) begin
                chk("scoreboard_empty", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("ser_out",    32'(ser_out),    32'(e.ser));
                chk("slot_idx",   32'(slot_idx),   32'(e.slot));
                chk("frame_sync", 32'(frame_sync), 32'(e.fs));
                chk("underrun",   32'(underrun),   32'(e.und));
                chk("enc_in",     32'(enc_in),     32'(e.enc));
                chk("ch_ready",   32'(ch_ready),   32'(e.rdy));
            end
            if (k == 0) begin
                ch_valid = vld_after;
                ch_data  = data_after;
            end
        end
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_ser_out"},    32'(ser_out),    32'd0);
        chk({tag, "_frame_sync"}, 32'(frame_sync), 32'd0);
        chk({tag, "_slot_idx"},   32'(slot_idx),   32'd0);
        chk({tag, "_underrun"},   32'(underrun),   32'd0);
        chk({tag, "_enc_in"},     32'(enc_in),     32'd0);
        chk({tag, "_ch_ready"},   32'(ch_ready),   32'hF);
    endtask

    initial begin
        logic [31:0] samp;
        logic [31:0] pcm;

        tbl[0] = '{8'h05, 8'h34};
        tbl[1] = '{8'h7F, 8'h0E};
        tbl[2] = '{8'h85, 8'hB4};
        tbl[3] = '{8'h00, 8'h31};
        tbl[4] = '{8'h2A, 8'h14};
        tbl[5] = '{8'h9C, 8'hAD};
        tbl[6] = '{8'hD0, 8'h85};
        tbl[7] = '{8'h13, 8'h22};

        rst_n    = 1'b0;
        en       = 1'b0;
        ch_valid = '0;
        ch_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        rst_n = 1'b1;

        // Idle with en low, then two empty frames back to back.
        expect_idle(2);
        drain(2, 4'h0, 32'h0);
        en = 1'b1;
        expect_frame(32'h0, 32'h0, 4'h0, 4'h0);
        expect_frame(32'h0, 32'h0, 4'h0, 4'h0);
        drain(128, 4'h0, 32'h0);

        // Table-driven frames: every channel loaded at the frame start edge.
        for (int f = 0; f < 2; f++) begin
            for (int c = 0; c < 4; c++) begin
                samp[8*c +: 8] = tbl[4*f + c].sample;
                pcm[8*c +: 8]  = tbl[4*f + c].pcm;
            end
            ch_valid = 4'hF;
            ch_data  = samp;
            expect_frame(pcm, samp, 4'hF, 4'h0);
            drain(64, 4'h0, samp);
        end

        // Channel 1 back-pressure: second sample held until the slot-2 load frees the buffer.
        ch_valid = 4'b0010;
        ch_data  = 32'h0000_2A00;
        expect_frame(32'h0000_1400, 32'h0000_2A00, 4'b0010, 4'b0010);
        drain(64, 4'b0010, 32'h0000_D000);
        expect_frame(32'h0000_8500, 32'h0000_D000, 4'b0010, 4'b0000);
        drain(64, 4'h0, 32'h0);

        // en dropped during slot 3: frame completes, then IDLE, then restart.
        expect_frame(32'h0, 32'h0, 4'h0, 4'h0);
        drain(25, 4'h0, 32'h0);
        en = 1'b0;
        drain(39, 4'h0, 32'h0);
        expect_idle(8);
        drain(8, 4'h0, 32'h0);
        en = 1'b1;
        expect_frame(32'h0, 32'h0, 4'h0, 4'h0);
        drain(64, 4'h0, 32'h0);

        // Reset during slot 2 with all buffers full; no stale samples afterwards.
        for (int c = 0; c < 4; c++) begin
            samp[8*c +: 8] = tbl[c].sample;
            pcm[8*c +: 8]  = tbl[c].pcm;
        end
        ch_valid = 4'hF;
        ch_data  = samp;
        expect_frame(pcm, samp, 4'hF, 4'hF);
        drain(21, 4'hF, samp);
        chk("full_before_reset", 32'(ch_ready), 32'h0);
        #3;
        rst_n    = 1'b0;
        en       = 1'b0;
        ch_valid = '0;
        #1;
        check_reset_values("midreset");
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        en    = 1'b1;
        expect_frame(32'h0, 32'h0, 4'h0, 4'h0);
        drain(64, 4'h0, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
